// File: rtl/data_mem_responder.sv
// Data-memory responder: services word/byte loads and stores to a big-endian array.
// Latency: w_ready pulses LATENCY cycles after the acceptance edge; w_busy covers those cycles.
// Backpressure: none queued; w_en is only sampled in IDLE, and requests seen while busy are ignored.
module data_mem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h80020000,
  parameter int          LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        w_en,
  input  logic        w_rw,
  input  logic        w_byte,
  input  logic        w_unsigned,
  input  logic [31:0] w_addr,
  input  logic [31:0] w_data_in,
  output logic [31:0] w_data_out,
  output logic        w_ready,
  output logic        w_err,
  output logic        w_busy
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          rw_q, rw_d, byte_q, byte_d, uns_q, uns_d;
  logic [31:0]   addr_q, addr_d, wdat_q, wdat_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [1:0]    lane_q, lane_d;
  logic [31:0]   dout_q, dout_d;
  logic          ready_q, ready_d, err_q, err_d, busy_q, busy_d;

  logic [31:0]   mem [DEPTH_WORDS];

  // Effective request: live inputs while accepting in IDLE (needed when LATENCY is 1), captured copy otherwise
  logic          eff_rw, eff_byte, eff_uns;
  logic [31:0]   eff_addr, offset, rd_word, load_val;
  logic [7:0]    lane_byte;
  logic          req_err, wr_en;

  // Sequencing: accept in IDLE, count down in WAIT, single RESP cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    byte_d  = byte_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    case (state_q)
      IDLE: begin
        if (w_en) begin
          rw_d    = w_rw;
          byte_d  = w_byte;
          uns_d   = w_unsigned;
          addr_d  = w_addr;
          wdat_d  = w_data_in;
          cnt_d   = CNT_INIT;
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_d == 4'd0) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Decode, error check and load formatting, evaluated as the FSM enters RESP
  always_comb begin
    eff_rw   = (state_q == IDLE) ? w_rw       : rw_q;
    eff_byte = (state_q == IDLE) ? w_byte     : byte_q;
    eff_uns  = (state_q == IDLE) ? w_unsigned : uns_q;
    eff_addr = (state_q == IDLE) ? w_addr     : addr_q;
    offset   = eff_addr - BASE_ADDR;
    req_err  = (eff_addr < BASE_ADDR) || ({1'b0, offset} >= SPAN) ||
               (!eff_byte && (offset[1:0] != 2'd0));
    rd_word  = mem[offset[AW+1:2]];
    case (offset[1:0])
      2'd0:    lane_byte = rd_word[31:24];
      2'd1:    lane_byte = rd_word[23:16];
      2'd2:    lane_byte = rd_word[15:8];
      default: lane_byte = rd_word[7:0];
    endcase
    if (!eff_byte)    load_val = rd_word;
    else if (eff_uns) load_val = {24'd0, lane_byte};
    else              load_val = {{24{lane_byte[7]}}, lane_byte};

    idx_d   = idx_q;
    lane_d  = lane_q;
    dout_d  = dout_q;
    ready_d = (state_d == RESP);
    err_d   = (state_d == RESP) && req_err;
    busy_d  = (state_d != IDLE);
    if (state_d == RESP) begin
      idx_d  = offset[AW+1:2];
      lane_d = offset[1:0];
      if (!eff_rw) dout_d = req_err ? 32'd0 : load_val;
    end
    // Store commits at the end of RESP, so a reset during the request never reaches the array
    wr_en = (state_q == RESP) && rw_q && !err_q;
  end

  // Control, captured request and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rw_q    <= 1'b0;
      byte_q  <= 1'b0;
      uns_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdat_q  <= 32'd0;
      idx_q   <= '0;
      lane_q  <= 2'd0;
      dout_q  <= 32'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      byte_q  <= byte_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      dout_q  <= dout_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Storage array (not reset); byte stores touch only their big-endian lane
  always_ff @(posedge clock) begin
    if (wr_en) begin
      if (byte_q) begin
        case (lane_q)
          2'd0:    mem[idx_q][31:24] <= wdat_q[7:0];
          2'd1:    mem[idx_q][23:16] <= wdat_q[7:0];
          2'd2:    mem[idx_q][15:8]  <= wdat_q[7:0];
          default: mem[idx_q][7:0]   <= wdat_q[7:0];
        endcase
      end else begin
        mem[idx_q] <= wdat_q;
      end
    end
  end

  assign w_data_out = dout_q;
  assign w_ready    = ready_q;
  assign w_err      = err_q;
  assign w_busy     = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed requests, expectations queued at issue time,
// a negedge monitor pops one expectation per w_ready pulse and checks err, data and busy length.
module tb_data_mem_responder;

  localparam int LATENCY = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        w_en = 1'b0, w_rw = 1'b0, w_byte = 1'b0, w_unsigned = 1'b0;
  logic [31:0] w_addr = 32'd0, w_data_in = 32'd0;
  logic [31:0] w_data_out;
  logic        w_ready, w_err, w_busy;

  data_mem_responder dut (
    .clock(clock), .reset_n(reset_n), .w_en(w_en), .w_rw(w_rw), .w_byte(w_byte),
    .w_unsigned(w_unsigned), .w_addr(w_addr), .w_data_in(w_data_in),
    .w_data_out(w_data_out), .w_ready(w_ready), .w_err(w_err), .w_busy(w_busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        err;
    logic [31:0] dout;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          issued = 0;
  int          readies = 0;
  int          busy_run = 0;
  logic [31:0] last_dout = 32'd0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every completion pulse must match the oldest queued expectation
  always @(negedge clock) begin
    exp_t e;
    if (!reset_n) busy_run = 0;
    else if (w_busy) busy_run++;
    if (w_ready) begin
      readies++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ready: w_ready seen with no outstanding request at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check32("resp_err", {31'd0, w_err}, {31'd0, e.err});
        check32("resp_data", w_data_out, e.dout);
        check32("busy_cycles", busy_run, LATENCY);
      end
      busy_run = 0;
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 20 && w_busy; i++) @(negedge clock);
  endtask

  task automatic wait_ready(input string name);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (w_ready) seen = 1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: no w_ready within 20 cycles, expected one", name);
    end
  endtask

  task automatic drive(input logic rw, input logic byt, input logic uns,
                       input logic [31:0] addr, input logic [31:0] data);
    wait_idle();
    w_rw = rw; w_byte = byt; w_unsigned = uns; w_addr = addr; w_data_in = data;
    w_en = 1'b1;
    @(posedge clock);
    #1 w_en = 1'b0;
  endtask

  task automatic do_load(input logic byt, input logic uns, input logic [31:0] addr,
                         input logic err, input logic [31:0] val);
    exp_t e;
    drive(1'b0, byt, uns, addr, 32'h5A5A5A5A);
    e.err = err;
    e.dout = err ? 32'd0 : val;
    last_dout = e.dout;
    exp_q.push_back(e);
    issued++;
    wait_ready("load");
  endtask

  task automatic do_store(input logic byt, input logic [31:0] addr, input logic [31:0] data,
                          input logic err);
    exp_t e;
    drive(1'b1, byt, 1'b0, addr, data);
    e.err = err;
    e.dout = last_dout;
    exp_q.push_back(e);
    issued++;
    wait_ready("store");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] lb_exp [4];
    logic [31:0] lbu_exp [4];
    exp_t e;
    lb_exp  = '{32'hFFFFFFDE, 32'hFFFFFFAD, 32'hFFFFFFBE, 32'hFFFFFFEF};
    lbu_exp = '{32'h000000DE, 32'h000000AD, 32'h000000BE, 32'h000000EF};

    // Reset with a request pending on the inputs: everything stays quiet
    w_en = 1'b1; w_rw = 1'b1; w_addr = 32'h80020000; w_data_in = 32'h11111111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check32("rst_data_out", w_data_out, 32'd0);
      check32("rst_ready", {31'd0, w_ready}, 32'd0);
      check32("rst_err", {31'd0, w_err}, 32'd0);
      check32("rst_busy", {31'd0, w_busy}, 32'd0);
    end
    w_en = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    do_store(1'b0, 32'h80020000, 32'hDEADBEEF, 1'b0);
    do_load(1'b0, 1'b0, 32'h80020000, 1'b0, 32'hDEADBEEF);
    repeat (3) @(negedge clock);
    check32("load_hold", w_data_out, 32'hDEADBEEF);

    for (int i = 0; i < 4; i++) begin
      do_load(1'b1, 1'b0, 32'h80020000 + 32'(i), 1'b0, lb_exp[i]);
      do_load(1'b1, 1'b1, 32'h80020000 + 32'(i), 1'b0, lbu_exp[i]);
    end

    do_store(1'b1, 32'h80020002, 32'hAABBCC12, 1'b0);
    do_load(1'b0, 1'b0, 32'h80020000, 1'b0, 32'hDEAD12EF);

    do_load(1'b0, 1'b0, 32'h80020001, 1'b1, 32'd0);
    do_store(1'b0, 32'h80021000, 32'h0BADF00D, 1'b1);
    do_load(1'b0, 1'b0, 32'h8001FFFC, 1'b1, 32'd0);
    do_load(1'b0, 1'b0, 32'h80020000, 1'b0, 32'hDEAD12EF);

    // Abort: store accepted, then reset during WAIT; nothing may complete or be written
    do_store(1'b0, 32'h80020004, 32'h00000000, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'h80020004, 32'hCAFEF00D);
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    check32("abort_busy", {31'd0, w_busy}, 32'd0);
    reset_n = 1'b1;
    last_dout = 32'd0;
    repeat (4) @(negedge clock);
    do_load(1'b0, 1'b0, 32'h80020004, 1'b0, 32'h00000000);

    // w_en toggled while busy with different request fields: ignored
    wait_idle();
    w_rw = 1'b0; w_byte = 1'b0; w_unsigned = 1'b0; w_addr = 32'h80020000;
    w_en = 1'b1;
    @(posedge clock);
    #1 w_rw = 1'b1; w_addr = 32'h80020004; w_data_in = 32'h77777777;
    e.err = 1'b0;
    e.dout = 32'hDEAD12EF;
    exp_q.push_back(e);
    issued++;
    @(posedge clock);
    #1 w_en = 1'b0;
    wait_ready("toggle");
    repeat (6) @(negedge clock);
    do_load(1'b0, 1'b0, 32'h80020004, 1'b0, 32'h00000000);

    repeat (4) @(negedge clock);
    check32("ready_count", readies, issued);
    check32("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the data-memory interface: accepts load/store requests driven by the data memory controller (enable, read/write, byte-select) plus address and store data, and services them after a fixed wait-state latency.
- Sits between the pipeline's memory stage and the data storage array.
- Supports word and byte accesses, with big-endian (MIPS) byte lanes and sign- or zero-extended byte loads.
- Flags misaligned and out-of-range accesses.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array; must be a power of two.
- BASE_ADDR, 32'h80020000, byte address of word 0; must be word aligned.
- LATENCY, 2, cycles from request acceptance to the response pulse; valid range 1..15.

Ports:
- clock  input  1  single clock; rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- w_en  input  1  request valid; sampled only in IDLE.
- w_rw  input  1  1 = store, 0 = load.
- w_byte  input  1  1 = byte access (LB/LBU/SB), 0 = word access (LW/SW).
- w_unsigned  input  1  byte loads only: 1 = zero-extend (LBU), 0 = sign-extend (LB).
- w_addr  input  32  byte address.
- w_data_in  input  32  store data; a byte store uses bits [7:0].
- w_data_out  output  32  load result.
- w_ready  output  1  one-cycle completion pulse.
- w_err  output  1  one-cycle error pulse, coincident with w_ready.
- w_busy  output  1  high from acceptance until the w_ready cycle, inclusive.

Behaviour:
- Reset values: w_data_out = 0, w_ready = 0, w_err = 0, w_busy = 0, FSM = IDLE, wait counter = 0. The storage array is not reset.
- Reset asserted mid-request aborts the request: no array write, no w_ready pulse.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - w_en = 1 at a clock edge accepts the request.
  - w_rw, w_byte, w_unsigned, w_addr and w_data_in are registered at acceptance.
  - Counter is loaded with LATENCY-1.
  - Next state is RESP if LATENCY = 1, otherwise WAIT.
  - w_busy goes high the cycle after acceptance.
- WAIT:
  - Counter decrements each cycle.
  - Moves to RESP when the counter reaches 0.
  - Input changes and w_en are ignored while busy; there is no queueing.
- RESP (one cycle):
  - The array access is performed.
  - w_ready = 1 for exactly this cycle.
  - Returns to IDLE, with w_busy falling the following cycle.
  - Net effect: w_ready is asserted LATENCY cycles after the acceptance edge.
- Address decode:
  - offset = addr - BASE_ADDR.
  - Word index = offset[log2(DEPTH_WORDS)+1:2].
  - Lane = offset[1:0].
- Error conditions (evaluated on the registered request):
  - addr < BASE_ADDR, or offset >= 4*DEPTH_WORDS: out of range.
  - Word access with lane != 0: misaligned.
  - On error: w_err = 1 together with w_ready; no write occurs; w_data_out is forced to 0 for a load; on a store, w_data_out is unchanged.
- Byte lanes are big-endian:
  - Lane 0 = bits [31:24]
  - Lane 1 = bits [23:16]
  - Lane 2 = bits [15:8]
  - Lane 3 = bits [7:0]
- Stores:
  - Word store (SW) writes the full word.
  - Byte store (SB) writes only the selected lane with w_data_in[7:0]; the other three lanes are preserved (read-modify-write, or per-lane write enable).
- Loads:
  - w_data_out is updated in the RESP cycle and holds until the next load completion or reset.
  - A word load returns the full word.
  - A byte load extracts the lane byte, then sign- or zero-extends it per w_unsigned.
- A store followed immediately by a load to the same address returns the stored data; there is no stale read.
- Back-to-back requests: w_en held high through RESP is re-accepted in the next IDLE cycle. Minimum spacing between acceptances is LATENCY+1 cycles.

Test Plan:
- Reset and latency:
  - Stimulus: reset_n low with w_en = 1, release, then SW 0xDEADBEEF to 0x80020000.
  - Required: all outputs 0 during reset; w_ready pulses exactly 2 cycles after acceptance (LATENCY = 2); w_busy high 2 cycles; w_err = 0.
- Word load:
  - Stimulus: LW 0x80020000 after the store above.
  - Required: w_data_out = 0xDEADBEEF at w_ready, held afterwards.
- Byte lanes and extension:
  - Stimulus: LB and LBU at 0x80020000..0x80020003.
  - Required: LB gives 0xFFFFFFDE, 0xFFFFFFAD, 0xFFFFFFBE, 0xFFFFFFEF; LBU gives 0x000000DE, 0x000000AD, 0x000000BE, 0x000000EF.
- Byte store:
  - Stimulus: SB 0x12 to 0x80020002, then LW 0x80020000.
  - Required: load returns 0xDEAD12EF.
- Errors:
  - Stimulus: LW 0x80020001; SW to 0x80021000 (DEPTH_WORDS = 1024); LW 0x8001FFFC.
  - Required: each produces w_err = w_ready = 1; loads return 0; the array is unchanged (verified by a follow-up LW 0x80020000 = 0xDEAD12EF).
- Abort and busy:
  - Stimulus 1: SW 0xCAFEF00D to 0x80020004, reset_n pulsed low in WAIT.
  - Required 1: no w_ready pulse; a later LW of 0x80020004 does not return 0xCAFEF00D (array pre-written with 0 before the test).
  - Stimulus 2: w_en toggled during WAIT.
  - Required 2: ignored; exactly one w_ready per accepted request.
